// File: rtl/sa_seq_if.sv
// Control, load-stream, result-stream and array-bus signals of the systolic-array sequencer.
interface sa_seq_if #(
   parameter int mac_w = 19,
   parameter int x_w   = 8
);
   logic             start_i;
   logic             reload_w_i;
   logic             busy_o;
   logic             done_o;
   logic             in_v_i;
   logic [x_w-1:0]   in_data_i;
   logic             in_ready_o;
   logic             out_v_o;
   logic [mac_w-1:0] out_data_o;
   logic             out_ready_i;
   logic [7:0]       addr_o;
   logic [x_w-1:0]   data_o;
   logic             wr_vo;
   logic [mac_w-1:0] rd_data_i;

   modport slave (
      input  start_i, reload_w_i, in_v_i, in_data_i, out_ready_i, rd_data_i,
      output busy_o, done_o, in_ready_o, out_v_o, out_data_o, addr_o, data_o, wr_vo
   );

   modport master (
      output start_i, reload_w_i, in_v_i, in_data_i, out_ready_i, rd_data_i,
      input  busy_o, done_o, in_ready_o, out_v_o, out_data_o, addr_o, data_o, wr_vo
   );
endinterface

// File: rtl/sa_seq.sv
// Job sequencer for an 8x8 systolic array: streams weights/activations onto the array bus,
// kicks the array, waits a fixed latency, then streams 64 results out under valid/ready.
module sa_seq #(
   parameter int mac_w    = 19,
   parameter int x_w      = 8,
   parameter int wait_cyc = 40
) (
   input logic     clk_i,
   input logic     rst_i,
   sa_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      LOAD_D = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      READ   = 3'd5
   } state_t;

   state_t           state;
   logic [5:0]       cnt;
   logic [5:0]       rcnt;
   logic [7:0]       wcnt;
   logic [7:0]       addr;
   logic [x_w-1:0]   data;
   logic             wr;
   logic             in_ready;
   logic             out_v;
   logic             busy;
   logic             done;
   logic             beat;
   logic             take;
   logic [mac_w-1:0] rd_q;

   assign beat = bus.in_v_i & in_ready;
   assign take = out_v & bus.out_ready_i;
   assign rd_q = bus.rd_data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         rcnt     <= '0;
         wcnt     <= '0;
         addr     <= '0;
         data     <= '0;
         wr       <= 1'b0;
         in_ready <= 1'b0;
         out_v    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= bus.reload_w_i ? LOAD_W : LOAD_D;
               end
            end
            LOAD_W: begin
               if (beat) begin
                  wr   <= 1'b1;
                  data <= bus.in_data_i;
                  addr <= {2'b00, cnt};
                  if (cnt == 6'd63) begin
                     cnt   <= '0;
                     state <= LOAD_D;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            LOAD_D: begin
               if (beat) begin
                  wr   <= 1'b1;
                  data <= bus.in_data_i;
                  addr <= {2'b01, cnt};
                  if (cnt == 6'd63) begin
                     cnt      <= '0;
                     in_ready <= 1'b0;
                     state    <= START;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            START: begin
               // Bus is registered, so the kick write lands in the first WAIT cycle;
               // the counter then covers wait_cyc quiet cycles after it.
               wr    <= 1'b1;
               addr  <= 8'hC0;
               data  <= '0;
               wcnt  <= 8'(wait_cyc);
               state <= WAIT;
            end
            WAIT: begin
               if (wcnt == 8'd0) begin
                  rcnt  <= '0;
                  addr  <= {2'b10, 6'd0};
                  out_v <= 1'b1;
                  state <= READ;
               end else begin
                  wcnt <= wcnt - 8'd1;
               end
            end
            READ: begin
               if (take) begin
                  if (rcnt == 6'd63) begin
                     rcnt  <= '0;
                     addr  <= '0;
                     out_v <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     rcnt <= rcnt + 6'd1;
                     addr <= {2'b10, rcnt + 6'd1};
                  end
               end
            end
            default: begin
               in_ready <= 1'b0;
               out_v    <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o     = busy;
   assign bus.done_o     = done;
   assign bus.in_ready_o = in_ready;
   assign bus.out_v_o    = out_v;
   assign bus.out_data_o = rd_q;
   assign bus.addr_o     = addr;
   assign bus.data_o     = data;
   assign bus.wr_vo      = wr;
endmodule
